// File: rtl/operand_issue.sv
// Operand issue stage: register file, per-register busy scoreboard and a
// one-entry output register that presents resolved ALU operands downstream.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_SEL_SIZE
`define ALU_SEL_SIZE 4
`endif
`ifndef ALU_NOP
`define ALU_NOP 4'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd1
`endif

module operand_issue #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_REGS   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [4:0]               in_rd,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic                     in_use_imm,
  input  logic                     in_we,
  input  logic [`ALU_SEL_SIZE-1:0] in_alu_sel,
  input  logic                     wb_en,
  input  logic [4:0]               wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_a,
  output logic [DATA_WIDTH-1:0]    out_b,
  output logic [`ALU_SEL_SIZE-1:0] out_alu_sel,
  output logic [4:0]               out_rd,
  output logic                     out_we
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf_q, rf_d;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;

  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_a_q, out_a_d;
  logic [DATA_WIDTH-1:0]    out_b_q, out_b_d;
  logic [`ALU_SEL_SIZE-1:0] out_alu_sel_q, out_alu_sel_d;
  logic [4:0]               out_rd_q, out_rd_d;
  logic                     out_we_q, out_we_d;

  logic                  rs1_wait, rs2_wait, rd_wait, hazard, accept;
  logic                  busy_set, flush_clr;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

  // A register whose writeback arrives this cycle is no longer a hazard.
  assign rs1_wait = (in_rs1 != 5'd0) && busy_q[in_rs1] && !(wb_en && wb_rd == in_rs1);
  assign rs2_wait = !in_use_imm && (in_rs2 != 5'd0) && busy_q[in_rs2]
                    && !(wb_en && wb_rd == in_rs2);
  assign rd_wait  = in_we && (in_rd != 5'd0) && busy_q[in_rd] && !(wb_en && wb_rd == in_rd);
  assign hazard   = rs1_wait || rs2_wait || rd_wait;

  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign busy_set  = accept && in_we && (in_rd != 5'd0);
  assign flush_clr = flush && out_valid_q && out_we_q && (out_rd_q != 5'd0);

  always_comb begin
    rs1_val = '0;
    if (in_rs1 != 5'd0) rs1_val = (wb_en && wb_rd == in_rs1) ? wb_data : rf_q[in_rs1];
  end

  always_comb begin
    rs2_val = '0;
    if (in_rs2 != 5'd0) rs2_val = (wb_en && wb_rd == in_rs2) ? wb_data : rf_q[in_rs2];
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign rf_d[gi]   = '0;
      assign busy_d[gi] = 1'b0;
    end else begin : g_arch
      always_comb begin
        rf_d[gi] = rf_q[gi];
        if (wb_en && wb_rd == 5'(gi)) rf_d[gi] = wb_data;
      end
      // Setting from a new issue takes priority over any clear in the same cycle.
      always_comb begin
        busy_d[gi] = busy_q[gi];
        if ((wb_en && wb_rd == 5'(gi)) || (flush_clr && out_rd_q == 5'(gi)))
          busy_d[gi] = 1'b0;
        if (busy_set && in_rd == 5'(gi))
          busy_d[gi] = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_alu_sel_d = out_alu_sel_q;
    out_rd_d      = out_rd_q;
    out_we_d      = out_we_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_a_d       = rs1_val;
      out_b_d       = in_use_imm ? in_imm : rs2_val;
      out_alu_sel_d = in_alu_sel;
      out_rd_d      = in_rd;
      out_we_d      = in_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q          <= '0;
      busy_q        <= '0;
      out_valid_q   <= 1'b0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_alu_sel_q <= `ALU_NOP;
      out_rd_q      <= 5'd0;
      out_we_q      <= 1'b0;
    end else begin
      rf_q          <= rf_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_alu_sel_q <= out_alu_sel_d;
      out_rd_q      <= out_rd_d;
      out_we_q      <= out_we_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_alu_sel = out_alu_sel_q;
  assign out_rd      = out_rd_q;
  assign out_we      = out_we_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed-vector bench for operand_issue: each check compares against a
// hand-computed constant and prints one line per mismatch plus a summary.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_SEL_SIZE
`define ALU_SEL_SIZE 4
`endif
`ifndef ALU_NOP
`define ALU_NOP 4'd0
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd1
`endif

module tb_operand_issue;
  localparam int DW = `DATA_WIDTH;
  localparam int SW = `ALU_SEL_SIZE;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [4:0]    in_rs1, in_rs2, in_rd;
  logic [DW-1:0] in_imm;
  logic          in_use_imm, in_we;
  logic [SW-1:0] in_alu_sel;
  logic          wb_en;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_a, out_b;
  logic [SW-1:0] out_alu_sel;
  logic [4:0]    out_rd;
  logic          out_we;

  int n_vectors     = 0;
  int n_miscompares = 0;

  operand_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_we(in_we),
    .in_alu_sel(in_alu_sel),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_alu_sel(out_alu_sel),
    .out_rd(out_rd), .out_we(out_we)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [DW-1:0] imm, input logic use_imm, input logic we,
                       input logic [SW-1:0] sel);
    in_valid   = 1'b1;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_we      = we;
    in_alu_sel = sel;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_imm = '0; in_use_imm = 1'b0; in_we = 1'b0; in_alu_sel = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_a", 64'(out_a), 64'd0);
    check_eq("rst_out_alu_sel", 64'(out_alu_sel), 64'(`ALU_NOP));
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Write x5 then issue ADD x5 + imm
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h10;
    tick();
    wb_en = 1'b0;
    issue(5'd5, 5'd0, 5'd1, 32'h3, 1'b1, 1'b0, `ALU_ADD);
    #1;
    check_eq("add_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle_in();
    check_eq("add_out_valid", 64'(out_valid), 64'd1);
    check_eq("add_out_a", 64'(out_a), 64'h10);
    check_eq("add_out_b", 64'(out_b), 64'h3);
    check_eq("add_alu_sel", 64'(out_alu_sel), 64'(`ALU_ADD));
    tick();
    check_eq("drain_out_valid", 64'(out_valid), 64'd0);

    // RAW hazard on x7 resolved by same-cycle writeback with bypass
    issue(5'd0, 5'd0, 5'd7, 32'h0, 1'b1, 1'b1, `ALU_ADD);
    tick();
    check_eq("busy7_set", 64'(dut.busy_q[7]), 64'd1);
    issue(5'd7, 5'd0, 5'd2, 32'h0, 1'b1, 1'b0, `ALU_ADD);
    #1;
    check_eq("raw_stall", 64'(in_ready), 64'd0);
    tick();
    check_eq("raw_stall_again", 64'(in_ready), 64'd0);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
    #1;
    check_eq("raw_wb_ready", 64'(in_ready), 64'd1);
    tick();
    idle_in(); wb_en = 1'b0;
    check_eq("bypass_out_valid", 64'(out_valid), 64'd1);
    check_eq("bypass_out_a", 64'(out_a), 64'h55);
    check_eq("busy7_clear", 64'(dut.busy_q[7]), 64'd0);
    tick();

    // Backpressure: hold for 3 cycles, outputs stable
    issue(5'd5, 5'd0, 5'd3, 32'h22, 1'b1, 1'b0, 4'd2);
    tick();
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd4, 32'h99, 1'b1, 1'b0, 4'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
      check_eq("hold_out_valid", 64'(out_valid), 64'd1);
      check_eq("hold_out_a", 64'(out_a), 64'h10);
      check_eq("hold_out_b", 64'(out_b), 64'h22);
      check_eq("hold_alu_sel", 64'(out_alu_sel), 64'd2);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle_in();
    check_eq("release_out_b", 64'(out_b), 64'h99);
    check_eq("release_alu_sel", 64'(out_alu_sel), 64'd3);
    check_eq("release_out_rd", 64'(out_rd), 64'd4);

    // x0 is never busy and never written
    issue(5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1, `ALU_ADD);
    tick();
    issue(5'd0, 5'd0, 5'd6, 32'h0, 1'b0, 1'b0, `ALU_ADD);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    check_eq("x0_no_stall", 64'(in_ready), 64'd1);
    tick();
    wb_en = 1'b0;
    check_eq("x0_bypass_a", 64'(out_a), 64'd0);
    check_eq("x0_bypass_b", 64'(out_b), 64'd0);
    issue(5'd0, 5'd0, 5'd6, 32'h0, 1'b1, 1'b0, `ALU_ADD);
    tick();
    idle_in();
    check_eq("x0_read_a", 64'(out_a), 64'd0);
    tick();

    // Flush a held x9 writer; x9 becomes free immediately
    out_ready = 1'b0;
    issue(5'd5, 5'd0, 5'd9, 32'h1, 1'b1, 1'b1, `ALU_ADD);
    tick();
    idle_in();
    check_eq("flush_held_rd", 64'(out_rd), 64'd9);
    check_eq("busy9_set", 64'(dut.busy_q[9]), 64'd1);
    flush = 1'b1;
    issue(5'd0, 5'd0, 5'd10, 32'h0, 1'b1, 1'b0, `ALU_ADD);
    #1;
    check_eq("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; idle_in();
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("busy9_clear", 64'(dut.busy_q[9]), 64'd0);
    out_ready = 1'b1;
    issue(5'd9, 5'd9, 5'd11, 32'h0, 1'b0, 1'b0, `ALU_ADD);
    #1;
    check_eq("x9_no_stall", 64'(in_ready), 64'd1);
    tick();
    idle_in();
    check_eq("x9_out_valid", 64'(out_valid), 64'd1);
    check_eq("x9_out_a", 64'(out_a), 64'd0);
    tick();

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    issue(5'd5, 5'd0, 5'd12, 32'h4, 1'b1, 1'b1, 4'd5);
    tick();
    idle_in();
    check_eq("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 64'(out_valid), 64'd0);
    check_eq("arst_out_a", 64'(out_a), 64'd0);
    check_eq("arst_out_b", 64'(out_b), 64'd0);
    check_eq("arst_alu_sel", 64'(out_alu_sel), 64'(`ALU_NOP));
    check_eq("arst_out_rd", 64'(out_rd), 64'd0);
    check_eq("arst_out_we", 64'(out_we), 64'd0);
    check_eq("arst_busy12", 64'(dut.busy_q[12]), 64'd0);
    check_eq("arst_x5", 64'(dut.rf_q[5]), 64'd0);
    tick();
    rst_n = 1'b1;
    issue(5'd12, 5'd0, 5'd12, 32'h0, 1'b1, 1'b1, `ALU_ADD);
    #1;
    check_eq("arst_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle_in();
    check_eq("arst_reissue_valid", 64'(out_valid), 64'd1);
    check_eq("arst_reissue_a", 64'(out_a), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, operand and register width.
REQ-002 Parameter NUM_REGS, default 32, architectural register count; register index width is 5 bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  decoded instruction present.
REQ-006 in_ready  output  1  stage can accept the instruction this cycle.
REQ-007 in_rs1, in_rs2, in_rd  input  5 each  source and destination register indices.
REQ-008 in_imm  input  DATA_WIDTH  sign-extended immediate.
REQ-009 in_use_imm  input  1  operand B is the immediate and rs2 is unused.
REQ-010 in_we  input  1  instruction writes rd.
REQ-011 in_alu_sel  input  `ALU_SEL_SIZE  ALU operation code.
REQ-012 wb_en, wb_rd, wb_data  input  1/5/DATA_WIDTH  writeback port.
REQ-013 flush  input  1  discards the instruction held in the output register.
REQ-014 out_valid  output  1  operands are valid for the ALU.
REQ-015 out_ready  input  1  downstream consumes the held instruction.
REQ-016 out_a, out_b  output  DATA_WIDTH  ALU operands a and b.
REQ-017 out_alu_sel  output  `ALU_SEL_SIZE  registered alu_sel for the ALU.
REQ-018 out_rd, out_we  output  5/1  destination passed downstream.

Function
REQ-019 The block SHALL contain a NUM_REGS x DATA_WIDTH register file; writes occur on wb_en with wb_rd != 0; x0 always reads 0 and is never written.
REQ-020 The block SHALL keep a per-register busy bit, set on accepting an instruction with in_we=1 and in_rd != 0, and cleared on wb_en for that wb_rd.
REQ-021 If a register is set and cleared in the same cycle, the set SHALL win.
REQ-022 hazard = (rs1 busy and not cleared this cycle) or (!in_use_imm and rs2 busy and not cleared this cycle) or (in_we and rd busy and not cleared this cycle); x0 is never busy.
REQ-023 in_ready = !flush and !hazard and (!out_valid or out_ready); the signal is combinational.
REQ-024 An instruction is accepted when in_valid and in_ready; on acceptance, out_* SHALL be loaded on the next edge, giving one-cycle latency.
REQ-025 Operand read SHALL bypass: if wb_en and wb_rd == rs and rs != 0, the operand is wb_data; otherwise it is the register-file value.
REQ-026 out_b = in_use_imm ? in_imm : rs2 operand; out_a = rs1 operand.
REQ-027 out_valid SHALL set on acceptance, clear when out_ready and no new acceptance, and stay at 1 across back-to-back acceptance.
REQ-028 While out_valid and !out_ready, all out_* SHALL hold stable.
REQ-029 When flush is asserted, out_valid SHALL clear on the next edge; if the flushed entry had out_we=1 and out_rd != 0, its busy bit SHALL clear.
REQ-030 No instruction is accepted in a flush cycle; writeback still proceeds.
REQ-031 The block SHALL perform no arithmetic; widths pass through unchanged.

Reset
REQ-032 While rst_n=0: out_valid=0, out_a=0, out_b=0, out_alu_sel=`ALU_NOP, out_rd=0, out_we=0, all busy bits 0, all registers 0.
REQ-033 After rst_n deasserts, in_ready SHALL be 1 in the first cycle.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction and all busy state.

Verification
REQ-035 Write x5=0x10 via wb; issue ADD rs1=5, use_imm, imm=0x3 -> next cycle out_valid=1, out_a=0x10, out_b=0x3, out_alu_sel=`ALU_ADD.
REQ-036 Issue rd=7 with we; then issue rs1=7 -> in_ready=0; wb_en with wb_rd=7, wb_data=0x55 in the same cycle as the retry -> accepted with out_a=0x55 (bypass), busy[7]=0.
REQ-037 Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready=0; release -> next instruction accepted that cycle.
REQ-038 Issue to rd=0 with we, then read rs1=0 -> no stall, out_a=0; wb_en with wb_rd=0, wb_data=0xFFFFFFFF -> x0 still reads 0.
REQ-039 Flush with held rd=9, we=1 -> out_valid=0 next cycle, busy[9]=0, an instruction reading x9 issues without stall.
REQ-040 Assert rst_n=0 asynchronously mid-stall -> outputs immediately take the REQ-032 values and in_ready=1 after release.
